// File: rtl/pieo_enq_fifo_tracker.sv
// pieo_enq_fifo_tracker: round-robin enqueue of non-empty, untracked FIFO IDs into a PIEO.
// Optional PIEO_ENQ_TRACKER_STATS_EN adds enq_count and spurious_end.
module pieo_enq_fifo_tracker #(
    parameter int NUM_QUEUES = 3,
    parameter int ID_LOG     = $clog2(NUM_QUEUES),
    parameter int RANK_LOG   = 1,
    parameter int TIME_LOG   = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en_in,
    input  logic [NUM_QUEUES-1:0]                 fifo_tvalid,
    input  logic [NUM_QUEUES-1:0]                 post_deq_end,
    input  logic                                  pieo_ready,
    output logic                                  pieo_enq_trigger,
    output logic [ID_LOG+RANK_LOG+TIME_LOG-1:0]   pieo_enq_element,
    output logic                                  fifos_not_enq_flag,
    output logic [NUM_QUEUES-1:0]                 tracked
`ifdef PIEO_ENQ_TRACKER_STATS_EN
    ,
    output logic [15:0]                           enq_count,
    output logic                                  spurious_end
`endif
);
    localparam int W = ID_LOG + RANK_LOG + TIME_LOG;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                state, state_next;
    logic [ID_LOG-1:0]     rr_ptr, sel;
    logic [NUM_QUEUES-1:0] pending, set_vec, clr_vec;
    logic                  go;

    assign pending = fifo_tvalid & ~tracked;
    assign go      = (state == IDLE) & en_in & pieo_ready & (|pending);
    assign set_vec = go ? (NUM_QUEUES'(1) << sel) : '0;
    assign clr_vec = post_deq_end & tracked;

    // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        sel = '0;
        for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
            int j;
            j = int'(rr_ptr) + k;
            j = (j >= NUM_QUEUES) ? j - NUM_QUEUES : j;
            if (pending[j]) sel = ID_LOG'(j);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = (state == HOLD) ? IDLE : (go ? HOLD : IDLE);
    end

    always_comb begin
        fifos_not_enq_flag = (en_in & (|pending)) | (state == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr           <= '0;
            tracked          <= '0;
            pieo_enq_trigger <= 1'b0;
            pieo_enq_element <= '0;
        end else begin
            tracked          <= (tracked & ~clr_vec) | set_vec;
            pieo_enq_trigger <= go;
            if (go) begin
                pieo_enq_element <= W'(sel);
                rr_ptr           <= (sel == ID_LOG'(NUM_QUEUES - 1)) ? '0 : sel + 1'b1;
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) (set_vec & clr_vec) == '0);

`ifdef PIEO_ENQ_TRACKER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enq_count    <= '0;
            spurious_end <= 1'b0;
        end else begin
            if (go && enq_count != 16'hFFFF) enq_count <= enq_count + 16'd1;
            if (|(post_deq_end & ~tracked)) spurious_end <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_pieo_enq_fifo_tracker.sv
// tb_pieo_enq_fifo_tracker: directed scenario tests for pieo_enq_fifo_tracker.
module tb_pieo_enq_fifo_tracker;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_in = 1'b1;
    logic [2:0] fifo_tvalid = '0;
    logic [2:0] post_deq_end = '0;
    logic       pieo_ready = 1'b1;
    logic       trig;
    logic [3:0] elem;
    logic       flag;
    logic [2:0] tracked;
`ifdef PIEO_ENQ_TRACKER_STATS_EN
    logic [15:0] enq_count;
    logic        spurious_end;
`endif
    int errors = 0;
    int checks = 0;

    pieo_enq_fifo_tracker dut (
        .clk(clk), .rst(rst), .en_in(en_in), .fifo_tvalid(fifo_tvalid),
        .post_deq_end(post_deq_end), .pieo_ready(pieo_ready),
        .pieo_enq_trigger(trig), .pieo_enq_element(elem),
        .fifos_not_enq_flag(flag), .tracked(tracked)
`ifdef PIEO_ENQ_TRACKER_STATS_EN
        , .enq_count(enq_count), .spurious_end(spurious_end)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_reset(input logic [2:0] tv, input logic en, input logic rdy);
        rst = 1'b1;
        fifo_tvalid = tv;
        en_in = en;
        pieo_ready = rdy;
        post_deq_end = '0;
        #2;
    endtask

    task automatic release_reset();
        step();
        rst = 1'b0;
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    task automatic test_reset();
        start_reset(3'b000, 1'b1, 1'b1);
        chk("rst_trig", {3'b0, trig}, 4'h0);
        chk("rst_elem", elem, 4'h0);
        chk("rst_tracked", {1'b0, tracked}, 4'h0);
        chk("rst_flag_idle", {3'b0, flag}, 4'h0);
        fifo_tvalid = 3'b010;
        #1;
        chk("rst_flag_pending", {3'b0, flag}, 4'h1);
        step();
        chk("rst_trig_held", {3'b0, trig}, 4'h0);
        post_deq_end = 3'b111;
        fifo_tvalid = 3'b000;
        rst = 1'b0;
        step();
        post_deq_end = 3'b000;
        chk("untracked_end_ignored", {1'b0, tracked}, 4'h0);
`ifdef PIEO_ENQ_TRACKER_STATS_EN
        chk("spurious_end", {3'b0, spurious_end}, 4'h1);
`endif
    endtask

    task automatic test_single();
        start_reset(3'b010, 1'b1, 1'b1);
        release_reset();
        step();
        chk("s1_trig", {3'b0, trig}, 4'h1);
        chk("s1_elem", elem, 4'h1);
        chk("s1_tracked", {1'b0, tracked}, 4'h2);
        chk("s1_flag_hold", {3'b0, flag}, 4'h1);
        fifo_tvalid = 3'b000;
        step();
        chk("s1_trig_off", {3'b0, trig}, 4'h0);
        chk("s1_flag_low", {3'b0, flag}, 4'h0);
        chk("s1_tracked_after_drop", {1'b0, tracked}, 4'h2);
    endtask

    task automatic test_round_robin();
        start_reset(3'b111, 1'b1, 1'b1);
        release_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s2_trig", {3'b0, trig}, 4'h1);
            chk("s2_elem", elem, 4'(i));
            step();
            chk("s2_gap", {3'b0, trig}, 4'h0);
        end
        chk("s2_tracked", {1'b0, tracked}, 4'h7);
        chk("s2_flag", {3'b0, flag}, 4'h0);
`ifdef PIEO_ENQ_TRACKER_STATS_EN
        chk("s2_enq_count", enq_count[3:0], 4'h3);
`endif
    endtask

    task automatic test_reenqueue();
        post_deq_end = 3'b001;
        step();
        post_deq_end = 3'b000;
        chk("s3_cleared", {1'b0, tracked}, 4'h6);
        chk("s3_no_trig_yet", {3'b0, trig}, 4'h0);
        chk("s3_flag", {3'b0, flag}, 4'h1);
        step();
        chk("s3_trig", {3'b0, trig}, 4'h1);
        chk("s3_elem", elem, 4'h0);
        chk("s3_tracked", {1'b0, tracked}, 4'h7);
        post_deq_end = 3'b110;
        step();
        post_deq_end = 3'b000;
        step();
        chk("s3_rr_next", elem, 4'h1);
        chk("s3_rr_trig", {3'b0, trig}, 4'h1);
        step();
        step();
        chk("s3_rr_last", elem, 4'h2);
    endtask

    task automatic test_enable();
        start_reset(3'b100, 1'b0, 1'b1);
        release_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s4_no_trig", {3'b0, trig}, 4'h0);
            chk("s4_flag_low", {3'b0, flag}, 4'h0);
        end
        en_in = 1'b1;
        #1;
        chk("s4_flag_on_en", {3'b0, flag}, 4'h1);
        step();
        chk("s4_trig", {3'b0, trig}, 4'h1);
        chk("s4_elem", elem, 4'h2);
        en_in = 1'b0;
        step();
        post_deq_end = 3'b100;
        step();
        post_deq_end = 3'b000;
        chk("s4_clear_while_disabled", {1'b0, tracked}, 4'h0);
        step();
        chk("s4_no_trig_disabled", {3'b0, trig}, 4'h0);
    endtask

    task automatic test_ready();
        start_reset(3'b001, 1'b1, 1'b0);
        release_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("s5_no_trig", {3'b0, trig}, 4'h0);
            chk("s5_flag", {3'b0, flag}, 4'h1);
        end
        pieo_ready = 1'b1;
        step();
        chk("s5_trig", {3'b0, trig}, 4'h1);
        chk("s5_elem", elem, 4'h0);
    endtask

    task automatic test_reset_abort();
        start_reset(3'b001, 1'b1, 1'b1);
        release_reset();
        step();
        chk("s6_trig_before", {3'b0, trig}, 4'h1);
        rst = 1'b1;
        #1;
        chk("s6_trig_drop", {3'b0, trig}, 4'h0);
        chk("s6_tracked", {1'b0, tracked}, 4'h0);
        chk("s6_elem", elem, 4'h0);
`ifdef PIEO_ENQ_TRACKER_STATS_EN
        chk("s6_enq_count", enq_count[3:0], 4'h0);
`endif
        step();
        chk("s6_trig_in_rst", {3'b0, trig}, 4'h0);
        rst = 1'b0;
        step();
        chk("s6_trig_after", {3'b0, trig}, 4'h1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_reenqueue();
        test_enable();
        test_ready();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pieo_enq_fifo_tracker.md
PIEO_ENQ_FIFO_TRACKER -- requirements
Module: pieo_enq_fifo_tracker

Interface
REQ-001 Parameter NUM_QUEUES, default 3, number of packet FIFOs and queue IDs.
REQ-002 Parameter ID_LOG, default $clog2(NUM_QUEUES), width of the queue ID field.
REQ-003 Parameter RANK_LOG, default 1, width of the rank field.
REQ-004 Parameter TIME_LOG, default 1, width of the time field.
REQ-005 clk  in  1  single clock; all state on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 en_in  in  1  scheduler enable; low blocks new enqueues.
REQ-008 fifo_tvalid  in  NUM_QUEUES  per-FIFO "head packet available".
REQ-009 post_deq_end  in  NUM_QUEUES  one-cycle pulse from the dequeue stage: service of queue i ended.
REQ-010 pieo_ready  in  1  PIEO can accept an operation this cycle.
REQ-011 pieo_enq_trigger  out  1  one-cycle enqueue strobe to the PIEO.
REQ-012 pieo_enq_element  out  ID_LOG+RANK_LOG+TIME_LOG  element {time, rank, id}, id in the LSBs.
REQ-013 fifos_not_enq_flag  out  1  a non-empty FIFO awaits enqueue; the dequeue stage holds off while high.
REQ-014 tracked  out  NUM_QUEUES  per-queue "ID is in the PIEO or in service" status.

Function
REQ-015 pending[i] SHALL be fifo_tvalid[i] & ~tracked[i].
REQ-016 The FSM SHALL have states IDLE and HOLD.
REQ-017 In IDLE with en_in=1, pieo_ready=1 and |pending=1, the block SHALL pulse pieo_enq_trigger for exactly one cycle and go to HOLD.
REQ-018 The enqueued ID SHALL be the first pending index at or after the round-robin pointer rr_ptr, wrapping at NUM_QUEUES-1 to 0.
REQ-019 On that enqueue, the block SHALL set tracked[id]=1 and set rr_ptr=id+1, wrapping to 0 after NUM_QUEUES-1.
REQ-020 pieo_enq_element SHALL be registered, with rank and time fields zero and the id in bits [ID_LOG-1:0]; the element SHALL never be all-ones.
REQ-021 The element SHALL be held stable while the trigger is high.
REQ-022 HOLD SHALL last exactly one cycle with no trigger, then return to IDLE.
REQ-023 Enqueue-to-next-enqueue spacing SHALL be at least 2 cycles.
REQ-024 post_deq_end[i]=1 SHALL clear tracked[i] on the next edge, in any state.
REQ-025 A post_deq_end pulse for an untracked queue SHALL be ignored.
REQ-026 If the clear and a new enqueue of the same ID occur in the same cycle, the set SHALL win; by construction the ID is not pending, so this cannot occur and an assertion SHALL check it.
REQ-027 A cleared queue whose FIFO is still non-empty SHALL become pending again and be re-enqueued behind the other pending queues (round robin).
REQ-028 fifos_not_enq_flag SHALL be combinational: (en_in & |pending) | (state==HOLD).
REQ-029 en_in=0 SHALL suppress new triggers only; tracked clears SHALL continue.
REQ-030 A FIFO dropping fifo_tvalid while tracked SHALL NOT clear its tracked bit; only post_deq_end clears it.

Reset
REQ-031 Asserting rst SHALL immediately force the following: state=IDLE, rr_ptr=0, tracked=0, pieo_enq_trigger=0, pieo_enq_element=0.
REQ-032 With those values, fifos_not_enq_flag SHALL follow REQ-028 during and after reset.
REQ-033 Reset asserted mid-HOLD or during the trigger cycle SHALL abort the operation; no trigger pulse SHALL appear after rst rises.
REQ-034 The first trigger after rst is released SHALL occur no earlier than the first rising edge after release.

Configuration
REQ-035 Macro PIEO_ENQ_TRACKER_STATS_EN, when defined, SHALL add output enq_count (16 bits): a saturating count of enqueue triggers, reset to 0.
REQ-036 The same macro SHALL add output spurious_end (1 bit): sticky, set by post_deq_end on an untracked queue, reset to 0.
REQ-037 With the macro undefined, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-038 Scenario 1: reset, fifo_tvalid=3'b010, pieo_ready=1, en_in=1 -> one trigger with element id=1; tracked=3'b010; flag low from the cycle after HOLD.
REQ-039 Scenario 2: fifo_tvalid=3'b111 from reset -> triggers with ids 0, 1, 2, each 2 cycles apart; tracked=3'b111.
REQ-040 Scenario 3: tracked=3'b111, post_deq_end=3'b001, fifo_tvalid[0] still 1 -> tracked[0] clears; id 0 is re-enqueued with the next trigger.
REQ-041 Scenario 4: en_in=0 with fifo_tvalid=3'b100 -> no trigger and flag=0; en_in raised -> id 2 is enqueued within 1 cycle.
REQ-042 Scenario 5: pieo_ready=0 for 5 cycles with pending=3'b001 -> no trigger and flag=1; the trigger fires in the cycle pieo_ready rises.
REQ-043 Scenario 6: rst asserted in the trigger cycle -> trigger drops immediately; tracked=0 and enq_count=0 (with the macro defined).
